// File: rtl/xsim_mem_arbiter_if.sv
// Signal bundle between the two memory clients, the arbiter and the
// simulation memory port. The arbiter connects through the slave modport;
// clients and the memory model connect through the master modport.
interface xsim_mem_arbiter_if;
  logic        c0_req_valid;
  logic        c0_req_write;
  logic [31:0] c0_req_handle;
  logic [31:0] c0_req_addr;
  logic [63:0] c0_req_wdata;
  logic        c0_req_ready;
  logic        c0_rsp_valid;
  logic [63:0] c0_rsp_data;
  logic        c0_rsp_ready;

  logic        c1_req_valid;
  logic        c1_req_write;
  logic [31:0] c1_req_handle;
  logic [31:0] c1_req_addr;
  logic [63:0] c1_req_wdata;
  logic        c1_req_ready;
  logic        c1_rsp_valid;
  logic [63:0] c1_rsp_data;
  logic        c1_rsp_ready;

  logic        en_read64;
  logic [31:0] read64_handle;
  logic [31:0] read64_addr;
  logic [63:0] read64_data;

  logic        en_write64;
  logic [31:0] write64_handle;
  logic [31:0] write64_addr;
  logic [63:0] write64_data;

  logic        busy;

  modport slave (
    input  c0_req_valid, c0_req_write, c0_req_handle, c0_req_addr, c0_req_wdata, c0_rsp_ready,
           c1_req_valid, c1_req_write, c1_req_handle, c1_req_addr, c1_req_wdata, c1_rsp_ready,
           read64_data,
    output c0_req_ready, c0_rsp_valid, c0_rsp_data,
           c1_req_ready, c1_rsp_valid, c1_rsp_data,
           en_read64, read64_handle, read64_addr,
           en_write64, write64_handle, write64_addr, write64_data,
           busy
  );

  modport master (
    output c0_req_valid, c0_req_write, c0_req_handle, c0_req_addr, c0_req_wdata, c0_rsp_ready,
           c1_req_valid, c1_req_write, c1_req_handle, c1_req_addr, c1_req_wdata, c1_rsp_ready,
           read64_data,
    input  c0_req_ready, c0_rsp_valid, c0_rsp_data,
           c1_req_ready, c1_rsp_valid, c1_rsp_data,
           en_read64, read64_handle, read64_addr,
           en_write64, write64_handle, write64_addr, write64_data,
           busy
  );
endinterface

// File: rtl/xsim_mem_arbiter.sv
// Two-client arbiter in front of a 64-bit simulation memory port.
// One transaction in flight at a time; round-robin or fixed priority.
module xsim_mem_arbiter #(
  parameter int RSP_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input logic               CLK,
  input logic               RST_N,
  xsim_mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ISSUE_W, ISSUE_R, WAIT_R, RSP} state_t;

  localparam logic [3:0] LAT = 4'(RSP_LAT);

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        win;
  logic        accept;
  logic        owner;
  logic [3:0]  cnt;
  logic [31:0] cmd_handle;
  logic [31:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic [63:0] rsp_data;

  // Arbitration, next-state decode and all handshake/enable outputs.
  always_comb begin
    state_nxt        = state;
    win              = 1'b0;
    accept           = 1'b0;
    bus.c0_req_ready = 1'b0;
    bus.c1_req_ready = 1'b0;
    bus.c0_rsp_valid = 1'b0;
    bus.c1_rsp_valid = 1'b0;
    bus.en_read64    = 1'b0;
    bus.en_write64   = 1'b0;
    case (state)
      IDLE: begin
        // Ready is held off while reset is asserted so nothing is granted then.
        if (RST_N && (bus.c0_req_valid || bus.c1_req_valid)) begin
          if (FIXED_PRIO != 0)
            win = !bus.c0_req_valid;
          else if (bus.c0_req_valid && bus.c1_req_valid)
            win = !last_grant;
          else
            win = bus.c1_req_valid;
          accept           = 1'b1;
          bus.c0_req_ready = !win;
          bus.c1_req_ready = win;
          if (win ? bus.c1_req_write : bus.c0_req_write)
            state_nxt = ISSUE_W;
          else
            state_nxt = ISSUE_R;
        end
      end
      ISSUE_W: begin
        bus.en_write64 = 1'b1;
        state_nxt      = IDLE;
      end
      ISSUE_R: begin
        bus.en_read64 = 1'b1;
        state_nxt     = WAIT_R;
      end
      WAIT_R: begin
        if (cnt <= 4'd1)
          state_nxt = RSP;
      end
      RSP: begin
        bus.c0_rsp_valid = !owner;
        bus.c1_rsp_valid = owner;
        if (owner ? bus.c1_rsp_ready : bus.c0_rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant pointer, latency counter and command/response registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= 4'd0;
      cmd_handle <= 32'd0;
      cmd_addr   <= 32'd0;
      cmd_wdata  <= 64'd0;
      rsp_data   <= 64'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= win;
        last_grant <= win;
        cmd_handle <= win ? bus.c1_req_handle : bus.c0_req_handle;
        cmd_addr   <= win ? bus.c1_req_addr   : bus.c0_req_addr;
        cmd_wdata  <= win ? bus.c1_req_wdata  : bus.c0_req_wdata;
      end
      if (state == ISSUE_R) begin
        cnt <= LAT;
      end else if (state == WAIT_R) begin
        cnt <= cnt - 4'd1;
        if (cnt <= 4'd1)
          rsp_data <= bus.read64_data;
      end
    end
  end

  // Command fields come straight from the registers so they hold between pulses.
  assign bus.read64_handle  = cmd_handle;
  assign bus.read64_addr    = cmd_addr;
  assign bus.write64_handle = cmd_handle;
  assign bus.write64_addr   = cmd_addr;
  assign bus.write64_data   = cmd_wdata;
  assign bus.c0_rsp_data    = owner ? 64'd0 : rsp_data;
  assign bus.c1_rsp_data    = owner ? rsp_data : 64'd0;
  assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_xsim_mem_arbiter.sv
// Bench for xsim_mem_arbiter: a round-robin instance with RSP_LAT=3 driven
// through a scoreboard, plus a fixed-priority instance with RSP_LAT=1.
module tb_xsim_mem_arbiter;
  localparam int LAT_A = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  xsim_mem_arbiter_if bus ();
  xsim_mem_arbiter_if bus_b ();

  xsim_mem_arbiter #(.RSP_LAT(LAT_A), .FIXED_PRIO(0)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));
  xsim_mem_arbiter #(.RSP_LAT(1), .FIXED_PRIO(1)) dut_b (.CLK(clk), .RST_N(rst_n), .bus(bus_b));

  typedef struct {
    bit          w;
    logic [31:0] h;
    logic [31:0] a;
    logic [63:0] d;
  } cmd_t;

  typedef struct {
    int          c;
    logic [63:0] d;
  } rsp_t;

  int   exp_grant [$];
  cmd_t exp_cmd [$];
  rsp_t exp_rsp [$];
  int   overlap = 0;

  logic [63:0] mem [logic [31:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input bit w, input logic [31:0] h, input logic [31:0] a, input logic [63:0] d);
    cmd_t e;
    e.w = w; e.h = h; e.a = a; e.d = d;
    exp_cmd.push_back(e);
  endtask

  task automatic push_rsp(input int c, input logic [63:0] d);
    rsp_t e;
    e.c = c; e.d = d;
    exp_rsp.push_back(e);
  endtask

  function automatic logic [63:0] rd_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a, ~a};
  endfunction

  initial forever @(posedge clk) cyc++;

  // Memory model: read data is only correct exactly LAT_A cycles after the pulse.
  initial begin
    int          rd_age;
    logic [31:0] rd_addr;
    rd_age = 100;
    rd_addr = 32'd0;
    mem[32'h10] = 64'hDEADBEEF_CAFEF00D;
    bus.read64_data = 64'd0;
    bus_b.read64_data = 64'd0;
    forever begin
      @(negedge clk);
      if (bus.en_write64) mem[bus.write64_addr] = bus.write64_data;
      if (bus.en_read64) begin
        rd_age = 0;
        rd_addr = bus.read64_addr;
      end else if (rd_age < 100) begin
        rd_age++;
      end
      bus.read64_data = (rd_age == LAT_A) ? rd_val(rd_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows a grant, command or response.
  initial begin
    bit prev_rv;
    int rd_cyc;
    prev_rv = 1'b0;
    rd_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.c0_req_valid && bus.c0_req_ready && bus.c1_req_valid && bus.c1_req_ready) begin
          tests++; fails++;
          $display("FAIL grant_both actual=both_ready required=one");
        end
        for (int c = 0; c < 2; c++) begin
          bit g;
          g = (c == 0) ? (bus.c0_req_valid && bus.c0_req_ready) : (bus.c1_req_valid && bus.c1_req_ready);
          if (g) begin
            if (exp_grant.size() == 0) begin
              tests++; fails++;
              $display("FAIL grant_unexpected actual=client%0d required=none", c);
            end else begin
              chk("grant_order", 64'(c), 64'(exp_grant.pop_front()));
            end
          end
        end
        if (bus.en_read64 && bus.en_write64) overlap++;
        if (bus.en_read64 || bus.en_write64) begin
          if (bus.en_read64) rd_cyc = cyc;
          if (exp_cmd.size() == 0) begin
            tests++; fails++;
            $display("FAIL cmd_unexpected actual=rd%0b/wr%0b addr=%h required=none",
                     bus.en_read64, bus.en_write64, bus.read64_addr);
          end else begin
            cmd_t e;
            e = exp_cmd.pop_front();
            chk("cmd_is_write", 64'(bus.en_write64), 64'(e.w));
            if (e.w) begin
              chk("wr_handle", 64'(bus.write64_handle), 64'(e.h));
              chk("wr_addr", 64'(bus.write64_addr), 64'(e.a));
              chk("wr_data", bus.write64_data, e.d);
            end else begin
              chk("rd_handle", 64'(bus.read64_handle), 64'(e.h));
              chk("rd_addr", 64'(bus.read64_addr), 64'(e.a));
            end
          end
        end
        if (bus.c0_rsp_valid && bus.c1_rsp_valid) begin
          tests++; fails++;
          $display("FAIL rsp_both actual=both_valid required=one");
        end
        if ((bus.c0_rsp_valid || bus.c1_rsp_valid) && !prev_rv)
          chk("rsp_latency", 64'(cyc - rd_cyc), 64'(LAT_A + 1));
        prev_rv = bus.c0_rsp_valid || bus.c1_rsp_valid;
        for (int c = 0; c < 2; c++) begin
          bit          t;
          logic [63:0] d;
          t = (c == 0) ? (bus.c0_rsp_valid && bus.c0_rsp_ready) : (bus.c1_rsp_valid && bus.c1_rsp_ready);
          d = (c == 0) ? bus.c0_rsp_data : bus.c1_rsp_data;
          if (t) begin
            if (exp_rsp.size() == 0) begin
              tests++; fails++;
              $display("FAIL rsp_unexpected actual=client%0d data=%h required=none", c, d);
            end else begin
              rsp_t e;
              e = exp_rsp.pop_front();
              chk("rsp_client", 64'(c), 64'(e.c));
              chk("rsp_data", d, e.d);
            end
          end
        end
      end else begin
        prev_rv = 1'b0;
      end
    end
  end

  task automatic issue(input int c, input bit w, input logic [31:0] h, input logic [31:0] a, input logic [63:0] d);
    bit got;
    got = 1'b0;
    if (c == 0) begin
      bus.c0_req_valid = 1'b1; bus.c0_req_write = w; bus.c0_req_handle = h;
      bus.c0_req_addr = a; bus.c0_req_wdata = d;
    end else begin
      bus.c1_req_valid = 1'b1; bus.c1_req_write = w; bus.c1_req_handle = h;
      bus.c1_req_addr = a; bus.c1_req_wdata = d;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (c == 0) ? bus.c0_req_ready : bus.c1_req_ready;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL accept_timeout actual=no_ready client=%0d required=ready", c);
    end
    @(posedge clk); #1;
    if (c == 0) bus.c0_req_valid = 1'b0;
    else bus.c1_req_valid = 1'b0;
  endtask

  // Holds both clients valid until each has been granted n times.
  task automatic hold_both(input int n);
    int g0, g1;
    g0 = 0; g1 = 0;
    for (int i = 0; i < 120 && (g0 < n || g1 < n); i++) begin
      @(negedge clk);
      if (bus.c0_req_valid && bus.c0_req_ready) g0++;
      if (bus.c1_req_valid && bus.c1_req_ready) g1++;
      @(posedge clk); #1;
      if (g0 >= n) bus.c0_req_valid = 1'b0;
      if (g1 >= n) bus.c1_req_valid = 1'b0;
    end
    if (g0 < n || g1 < n) begin
      tests++; fails++;
      $display("FAIL hold_both_timeout actual=%0d/%0d required=%0d", g0, g1, n);
    end
    bus.c0_req_valid = 1'b0;
    bus.c1_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 60 && !idle; i++) begin
      @(negedge clk);
      idle = !bus.busy;
    end
    if (!idle) begin
      tests++; fails++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int quiet, g0b, g1b;
    bit got, seen;
    bus.c0_req_valid = 1'b1; bus.c0_req_write = 1'b0; bus.c0_req_handle = 32'd2;
    bus.c0_req_addr = 32'h100; bus.c0_req_wdata = 64'd0; bus.c0_rsp_ready = 1'b1;
    bus.c1_req_valid = 1'b1; bus.c1_req_write = 1'b0; bus.c1_req_handle = 32'd3;
    bus.c1_req_addr = 32'h200; bus.c1_req_wdata = 64'd0; bus.c1_rsp_ready = 1'b1;
    bus_b.c0_req_valid = 1'b0; bus_b.c0_req_write = 1'b1; bus_b.c0_req_handle = 32'd8;
    bus_b.c0_req_addr = 32'h80; bus_b.c0_req_wdata = 64'hAAAA; bus_b.c0_rsp_ready = 1'b1;
    bus_b.c1_req_valid = 1'b0; bus_b.c1_req_write = 1'b1; bus_b.c1_req_handle = 32'd9;
    bus_b.c1_req_addr = 32'h90; bus_b.c1_req_wdata = 64'hBBBB; bus_b.c1_rsp_ready = 1'b1;

    // Reset state, with both clients already requesting.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_c0_ready", 64'(bus.c0_req_ready), 64'd0);
    chk("rst_c1_ready", 64'(bus.c1_req_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_en_read", 64'(bus.en_read64), 64'd0);
    chk("rst_en_write", 64'(bus.en_write64), 64'd0);
    chk("rst_rsp_valid", 64'(bus.c0_rsp_valid | bus.c1_rsp_valid), 64'd0);
    chk("rst_rd_addr", 64'(bus.read64_addr), 64'd0);
    chk("rst_wr_data", bus.write64_data, 64'd0);
    chk("rst_rsp_data", bus.c0_rsp_data, 64'd0);

    // Contention from reset: c0, c1, c0, c1.
    for (int k = 0; k < 2; k++) begin
      exp_grant.push_back(0); push_cmd(1'b0, 32'd2, 32'h100, 64'd0); push_rsp(0, 64'h00000100_FFFFFEFF);
      exp_grant.push_back(1); push_cmd(1'b0, 32'd3, 32'h200, 64'd0); push_rsp(1, 64'h00000200_FFFFFDFF);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold_both(2);
    wait_idle();

    // Single read by c0.
    exp_grant.push_back(0); push_cmd(1'b0, 32'd1, 32'h10, 64'd0); push_rsp(0, 64'hDEADBEEF_CAFEF00D);
    issue(0, 1'b0, 32'd1, 32'h10, 64'd0);
    wait_idle();

    // c1 write then read back.
    exp_grant.push_back(1); push_cmd(1'b1, 32'd7, 32'h20, 64'h01234567_89ABCDEF);
    issue(1, 1'b1, 32'd7, 32'h20, 64'h01234567_89ABCDEF);
    exp_grant.push_back(1); push_cmd(1'b0, 32'd7, 32'h20, 64'd0); push_rsp(1, 64'h01234567_89ABCDEF);
    issue(1, 1'b0, 32'd7, 32'h20, 64'd0);
    wait_idle();
    chk("cmd_hold_addr", 64'(bus.read64_addr), 64'h20);
    chk("cmd_hold_handle", 64'(bus.read64_handle), 64'd7);

    // Backpressure on c0 while c1 waits with a write.
    bus.c0_rsp_ready = 1'b0;
    exp_grant.push_back(0); push_cmd(1'b0, 32'd4, 32'h30, 64'd0); push_rsp(0, 64'h00000030_FFFFFFCF);
    issue(0, 1'b0, 32'd4, 32'h30, 64'd0);
    exp_grant.push_back(1); push_cmd(1'b1, 32'd5, 32'h40, 64'h11112222_33334444);
    bus.c1_req_valid = 1'b1; bus.c1_req_write = 1'b1; bus.c1_req_handle = 32'd5;
    bus.c1_req_addr = 32'h40; bus.c1_req_wdata = 64'h11112222_33334444;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = bus.c0_rsp_valid;
    end
    chk("bp_rsp_arrives", 64'(got), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 64'(bus.c0_rsp_valid), 64'd1);
      chk("bp_rsp_data", bus.c0_rsp_data, 64'h00000030_FFFFFFCF);
      chk("bp_c1_ready", 64'(bus.c1_req_ready), 64'd0);
      chk("bp_busy", 64'(bus.busy), 64'd1);
    end
    @(posedge clk); #1;
    bus.c0_rsp_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.c1_req_ready;
    end
    chk("bp_c1_granted", 64'(got), 64'd1);
    @(posedge clk); #1;
    bus.c1_req_valid = 1'b0;
    wait_idle();

    // Reset while c0's read is waiting for data.
    exp_grant.push_back(0); push_cmd(1'b0, 32'd6, 32'h70, 64'd0);
    issue(0, 1'b0, 32'd6, 32'h70, 64'd0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.en_read64;
    end
    chk("abort_read_issued", 64'(got), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_rst_rd_addr", 64'(bus.read64_addr), 64'd0);
    chk("abort_rst_rsp_data", bus.c0_rsp_data, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.c0_rsp_valid || bus.c1_rsp_valid || bus.en_read64 || bus.en_write64 || bus.busy) quiet++;
    end
    chk("abort_quiet", 64'(quiet), 64'd0);
    @(posedge clk); #1;
    exp_grant.push_back(0); push_cmd(1'b1, 32'd10, 32'h50, 64'h55);
    exp_grant.push_back(1); push_cmd(1'b1, 32'd11, 32'h60, 64'h66);
    bus.c0_req_valid = 1'b1; bus.c0_req_write = 1'b1; bus.c0_req_handle = 32'd10;
    bus.c0_req_addr = 32'h50; bus.c0_req_wdata = 64'h55;
    bus.c1_req_valid = 1'b1; bus.c1_req_write = 1'b1; bus.c1_req_handle = 32'd11;
    bus.c1_req_addr = 32'h60; bus.c1_req_wdata = 64'h66;
    hold_both(1);
    wait_idle();

    // Fixed priority: c0 always wins while valid, c1 only once c0 drops.
    bus_b.c0_req_valid = 1'b1;
    bus_b.c1_req_valid = 1'b1;
    g0b = 0; g1b = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_b.c0_req_valid && bus_b.c0_req_ready) g0b++;
      if (bus_b.c1_req_valid && bus_b.c1_req_ready) g1b++;
    end
    chk("fp_c1_grants", 64'(g1b), 64'd0);
    chk("fp_c0_grants_ge10", 64'(g0b >= 10), 64'd1);
    @(posedge clk); #1;
    bus_b.c0_req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = bus_b.c1_req_ready;
    end
    chk("fp_c1_alone_wins", 64'(seen), 64'd1);
    @(posedge clk); #1;
    bus_b.c1_req_valid = 1'b0;
    repeat (4) @(posedge clk);

    chk("sb_grants_left", 64'(exp_grant.size()), 64'd0);
    chk("sb_cmds_left", 64'(exp_cmd.size()), 64'd0);
    chk("sb_rsps_left", 64'(exp_rsp.size()), 64'd0);
    chk("en_overlap", 64'(overlap), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xsim_mem_arbiter.md
XSIM_MEM_ARBITER -- requirements
Module: xsim_mem_arbiter

Interface
REQ-001 Parameter RSP_LAT, default 1: cycles from the en_read64 pulse until read64_data is valid; legal range 1..15.
REQ-002 Parameter FIXED_PRIO, default 0: 0 selects round-robin; 1 makes client 0 always win.
REQ-003 CLK  input  1  sole clock; all logic samples on posedge CLK.
REQ-004 RST_N  input  1  reset, synchronous and active-low.
REQ-005 cN_req_valid  input  1  request from client N, where N is 0 or 1.
REQ-006 cN_req_write  input  1  1 = 64-bit write, 0 = 64-bit read.
REQ-007 cN_req_handle  input  32  memory region handle.
REQ-008 cN_req_addr  input  32  byte address within the region.
REQ-009 cN_req_wdata  input  64  write data; ignored for reads.
REQ-010 cN_req_ready  output  1  request accepted when valid and ready are both high.
REQ-011 cN_rsp_valid  output  1  read data available to client N.
REQ-012 cN_rsp_data  output  64  read data.
REQ-013 cN_rsp_ready  input  1  client N consumes the response.
REQ-014 en_read64, read64_handle, read64_addr  output  1/32/32  read command to the simulation memory port.
REQ-015 read64_data  input  64  read return from the memory port.
REQ-016 en_write64, write64_handle, write64_addr, write64_data  output  1/32/32/64  write command to the memory port.
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE_W, ISSUE_R, WAIT_R and RSP; at most one transaction is outstanding.
REQ-019 In IDLE the arbiter SHALL choose a winner combinationally from the valid requests and drive cN_req_ready=1 for the winner only; ready SHALL be 0 in every other state.
REQ-020 Round-robin: when both clients are valid, the winner SHALL be the client not granted last; a single valid client SHALL always win.
REQ-021 With FIXED_PRIO=1, client 0 SHALL win whenever c0_req_valid=1.
REQ-022 On acceptance, handle, addr, wdata and the client id SHALL be registered, the last-grant pointer SHALL be updated, and the next state SHALL be ISSUE_W for a write or ISSUE_R for a read.
REQ-023 ISSUE_W SHALL drive en_write64=1 with the registered fields for exactly one cycle, then return to IDLE; writes produce no response.
REQ-024 ISSUE_R SHALL drive en_read64=1 with the registered fields for exactly one cycle, then go to WAIT_R and load a 4-bit counter with RSP_LAT.
REQ-025 WAIT_R SHALL decrement the counter every cycle; in the cycle the counter reaches 1, read64_data SHALL be captured into the response register and the state SHALL go to RSP.
REQ-026 RSP SHALL hold cN_rsp_valid=1 and a stable cN_rsp_data for the owning client only, until cN_rsp_ready=1, then return to IDLE.
REQ-027 The minimum spacing between accepts SHALL be 2 cycles for a write and RSP_LAT+3 cycles for a read with rsp_ready held high.
REQ-028 en_read64 and en_write64 SHALL never be high in the same cycle, and each SHALL be low outside its ISSUE state.
REQ-029 Command address, handle and data outputs SHALL hold their last registered values when their enable is low.
REQ-030 A request that drops valid before acceptance SHALL be treated as never made; no protocol error is flagged.

Reset
REQ-031 While RST_N=0 at a posedge, the block SHALL enter IDLE with all of the following cleared to 0: ready, rsp_valid, enables, busy, counter, response register and command registers; the last-grant pointer SHALL be set so that client 0 wins the next tie.
REQ-032 Reset asserted mid-transaction SHALL abort the transaction: no further enable pulse, no response, and no pending state after release.

Verification
REQ-033 Single read: c0 reads handle=1, addr=0x10; memory returns 0xDEADBEEF_CAFEF00D -> one en_read64 pulse, then c0_rsp_valid with that data RSP_LAT+1 cycles later; c1 sees nothing.
REQ-034 Contention: both clients hold valid reads from reset -> grants go c0, c1, c0, c1; each client's rsp_data matches its own address.
REQ-035 Write then read: c1 writes 0x0123456789ABCDEF at addr 0x20, then reads addr 0x20 -> en_write64 pulse carrying that data, followed by a response of 0x0123456789ABCDEF.
REQ-036 Backpressure: c0_rsp_ready held at 0 for 5 cycles -> rsp_valid and rsp_data stay stable, c1_req_ready stays 0, and busy stays 1.
REQ-037 Reset in WAIT_R with RSP_LAT=3 -> no rsp_valid, enables stay 0, and the first request after release is granted to c0.
REQ-038 FIXED_PRIO=1 with both clients continuously valid -> c1 is never granted.
